// File: rtl/int_add_issue.sv
// Issue/capture wrapper around the pipelined 32-bit adder: buffers ADD/SUB/ADC requests,
// drives the adder with credit and carry-hazard interlocks, and queues flagged results in order.
module int_add_issue #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int ADD_LAT   = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_cin,
  input  logic [31:0]      add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int IAW   = $clog2(IN_DEPTH);
  localparam int OAW   = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + ADD_LAT + 2);
  localparam logic [IAW:0]     IONE   = 1;
  localparam logic [OAW:0]     OONE   = 1;
  localparam logic [CNT_W-1:0] OCREDIT = CNT_W'(OUT_DEPTH);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;

  logic [1:0]       iq_op  [IN_DEPTH];
  logic [31:0]      iq_a   [IN_DEPTH];
  logic [31:0]      iq_b   [IN_DEPTH];
  logic [TAG_W-1:0] iq_tag [IN_DEPTH];
  logic [IAW:0]     iq_wr, iq_rd;
  logic             iq_empty, iq_full, push_in;

  // Stage 0 sits alongside the adder input registers; stage ADD_LAT lines up with add_sum.
  logic             pv   [ADD_LAT+1];
  logic [TAG_W-1:0] ptag [ADD_LAT+1];
  logic             pa31 [ADD_LAT+1];
  logic             pb31 [ADD_LAT+1];

  logic [31:0]      oq_sum [OUT_DEPTH];
  logic [TAG_W-1:0] oq_tag [OUT_DEPTH];
  logic [3:0]       oq_flg [OUT_DEPTH];
  logic [OAW:0]     oq_wr, oq_rd, oq_occ;
  logic             pop_out, cap;

  logic             cf;
  logic [1:0]       h_op;
  logic [31:0]      h_a, h_b, dec_b;
  logic [TAG_W-1:0] h_tag;
  logic             dec_cin, issue, credit_ok;
  logic [CNT_W-1:0] inflight;
  logic             cap_v;

  assign iq_empty = (iq_wr == iq_rd);
  assign iq_full  = (iq_wr[IAW] != iq_rd[IAW]) && (iq_wr[IAW-1:0] == iq_rd[IAW-1:0]);
  assign in_ready = !iq_full;
  assign push_in  = in_valid && in_ready;

  assign h_op  = iq_op[iq_rd[IAW-1:0]];
  assign h_a   = iq_a[iq_rd[IAW-1:0]];
  assign h_b   = iq_b[iq_rd[IAW-1:0]];
  assign h_tag = iq_tag[iq_rd[IAW-1:0]];

  always_comb begin
    dec_b   = h_b;
    dec_cin = 1'b0;
    if (h_op == OP_SUB) begin
      dec_b   = ~h_b;
      dec_cin = 1'b1;
    end else if (h_op == OP_ADC) begin
      dec_cin = cf;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ADD_LAT; i++)
      inflight = inflight + {{(CNT_W-1){1'b0}}, pv[i]};
  end

  assign oq_occ    = oq_wr - oq_rd;
  assign credit_ok = (inflight + CNT_W'(oq_occ)) < OCREDIT;
  // ADC must see the carry of the previous op, so it waits for the pipe to drain.
  assign issue     = !iq_empty && credit_ok && ((h_op != OP_ADC) || (inflight == '0));

  assign cap     = pv[ADD_LAT];
  assign cap_v   = (pa31[ADD_LAT] == pb31[ADD_LAT]) && (add_sum[31] != pa31[ADD_LAT]);
  assign out_valid = (oq_wr != oq_rd);
  assign pop_out   = out_valid && out_ready;

  assign out_sum = oq_sum[oq_rd[OAW-1:0]];
  assign out_tag = oq_tag[oq_rd[OAW-1:0]];
  assign {out_c, out_v, out_z, out_n} = oq_flg[oq_rd[OAW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq_wr   <= '0;
      iq_rd   <= '0;
      oq_wr   <= '0;
      oq_rd   <= '0;
      cf      <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      for (int i = 0; i < IN_DEPTH; i++) begin
        iq_op[i]  <= '0;
        iq_a[i]   <= '0;
        iq_b[i]   <= '0;
        iq_tag[i] <= '0;
      end
      for (int i = 0; i <= ADD_LAT; i++) begin
        pv[i]   <= 1'b0;
        ptag[i] <= '0;
        pa31[i] <= 1'b0;
        pb31[i] <= 1'b0;
      end
      for (int i = 0; i < OUT_DEPTH; i++) begin
        oq_sum[i] <= '0;
        oq_tag[i] <= '0;
        oq_flg[i] <= '0;
      end
    end else begin
      if (push_in) begin
        iq_op[iq_wr[IAW-1:0]]  <= in_op;
        iq_a[iq_wr[IAW-1:0]]   <= in_a;
        iq_b[iq_wr[IAW-1:0]]   <= in_b;
        iq_tag[iq_wr[IAW-1:0]] <= in_tag;
        iq_wr <= iq_wr + IONE;
      end

      if (issue) begin
        iq_rd   <= iq_rd + IONE;
        add_a   <= h_a;
        add_b   <= dec_b;
        add_cin <= dec_cin;
      end

      pv[0]   <= issue;
      ptag[0] <= h_tag;
      pa31[0] <= h_a[31];
      pb31[0] <= dec_b[31];
      for (int i = 1; i <= ADD_LAT; i++) begin
        pv[i]   <= pv[i-1];
        ptag[i] <= ptag[i-1];
        pa31[i] <= pa31[i-1];
        pb31[i] <= pb31[i-1];
      end

      if (cap) begin
        oq_sum[oq_wr[OAW-1:0]] <= add_sum;
        oq_tag[oq_wr[OAW-1:0]] <= ptag[ADD_LAT];
        oq_flg[oq_wr[OAW-1:0]] <= {add_cout, cap_v, (add_sum == 32'd0), add_sum[31]};
        oq_wr <= oq_wr + OONE;
        cf    <= add_cout;
      end

      if (pop_out)
        oq_rd <= oq_rd + OONE;
    end
  end

endmodule

// File: tb/tb_int_add_issue.sv
// Directed bench for int_add_issue with a one-cycle adder model; expected results are hand-computed.
module tb_int_add_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_c, out_v, out_z, out_n;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int_add_issue #(.IN_DEPTH(4), .OUT_DEPTH(4), .ADD_LAT(1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tag(out_tag),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // one-edge adder
  initial begin
    add_sum  = '0;
    add_cout = 1'b0;
  end
  always @(posedge clk)
    {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tg, output int acc);
    bit ok;
    int w;
    w = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tg;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      w++;
      if (w > 100) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] s, output logic [3:0] t, output logic [3:0] f,
                      output int at);
    int w;
    w = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      w++;
      if (w > 100) begin
        chk("recv_timeout", 64'd0, 64'd1);
        break;
      end
    end
    s  = out_sum;
    t  = out_tag;
    f  = {out_c, out_v, out_z, out_n};
    at = cyc;
    @(posedge clk); #1;
  endtask

  // flags are packed {C,V,Z,N}; an idle pipe gives out_valid 3 edges after acceptance
  task automatic do_one(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tg,
                        input logic [31:0] es, input logic [3:0] ef);
    int acc, at;
    logic [31:0] s;
    logic [3:0]  t, f;
    send(op, a, b, tg, acc);
    recv(s, t, f, at);
    chk({nm, "_sum"}, 64'(s), 64'(es));
    chk({nm, "_tag"}, 64'(t), 64'(tg));
    chk({nm, "_flags"}, 64'(f), 64'(ef));
    chk({nm, "_lat"}, 64'(at - acc), 64'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, at0, at1, dummy, stale;
    logic [31:0] s;
    logic [3:0]  t, f;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    chk("rst_add_cin", 64'(add_cin), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_one("add_wrap",  2'b00, 32'hffffffd9, 32'h00000062, 4'd3, 32'h0000003b, 4'b1000);
    do_one("sub_neg",   2'b01, 32'h00000005, 32'h00000007, 4'd5, 32'hfffffffe, 4'b0001);
    do_one("sub_zero",  2'b01, 32'h12345678, 32'h12345678, 4'd6, 32'h00000000, 4'b1010);
    do_one("sub_pos",   2'b01, 32'h00000010, 32'h00000003, 4'd4, 32'h0000000d, 4'b1000);
    do_one("add_ovf",   2'b00, 32'h7fffffff, 32'h00000001, 4'd7, 32'h80000000, 4'b0101);
    do_one("add_carry", 2'b00, 32'hffffffff, 32'h00000001, 4'd8, 32'h00000000, 4'b1010);
    do_one("rsv_add",   2'b11, 32'h00000003, 32'h00000004, 4'd9, 32'h00000007, 4'b0000);

    // ADC right behind a carry-producing ADD must wait for it to retire
    send(2'b00, 32'hffffffff, 32'h00000001, 4'd1, acc0);
    send(2'b10, 32'h00000001, 32'h00000001, 4'd2, acc1);
    recv(s, t, f, at0);
    chk("b2b_add_sum", 64'(s), 64'h0);
    chk("b2b_add_flags", 64'(f), 64'(4'b1010));
    recv(s, t, f, at1);
    chk("b2b_adc_sum", 64'(s), 64'h3);
    chk("b2b_adc_tag", 64'(t), 64'd2);
    chk("b2b_adc_lat", 64'(at1 - acc1), 64'd5);
    do_one("adc_cf0", 2'b10, 32'h00000001, 32'h00000001, 4'd10, 32'h00000002, 4'b0000);

    // backpressure: 4 results buffered + 4 queued fills everything
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(2'b00, 32'(i * 17), 32'h100, 4'(i), dummy);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_tag", 64'(out_tag), 64'd0);
    chk("bp_head_sum", 64'(out_sum), 64'h100);
    @(posedge clk); #1;
    fork
      begin
        send(2'b00, 32'(8 * 17), 32'h100, 4'd8, dummy);
        send(2'b00, 32'(9 * 17), 32'h100, 4'd9, dummy);
      end
      begin
        for (int j = 0; j < 10; j++) begin
          recv(s, t, f, at0);
          chk($sformatf("bp_sum%0d", j), 64'(s), 64'(32'(j * 17) + 32'h100));
          chk($sformatf("bp_tag%0d", j), 64'(t), 64'(j));
        end
      end
    join
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // reset with results buffered, ops in flight and queued
    out_ready = 1'b0;
    send(2'b00, 32'd1, 32'd2, 4'd1, dummy);
    send(2'b00, 32'd3, 32'd4, 4'd2, dummy);
    send(2'b00, 32'd5, 32'd6, 4'd3, dummy);
    send(2'b00, 32'd7, 32'd8, 4'd4, dummy);
    @(negedge clk);
    chk("prerst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_add_a", 64'(add_a), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("postrst_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;
    do_one("postrst_add", 2'b00, 32'h00000010, 32'h00000020, 4'd12, 32'h00000030, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
